maxi_loader: RTL and testbench

MAXI_LOADER -- requirements
Module: maxi_loader

---
 rtl/maxi_loader.sv | 77 +++++++
 tb/tb_maxi_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/maxi_loader.sv
// Purpose: collects a stream of words into a 2*N-slot vector for the max reducer, zero-padding short sets.
// Latency: vec_valid rises 1 cycle after the completing word is accepted; 1 word/cycle sustained in FILL.
// Backpressure: in_ready drops for the whole FULL phase; the vector is held until vec_valid && vec_ready.
module maxi_loader #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [2*N*DATA_WIDTH-1:0]    vec,
    output logic                         vec_valid,
    input  logic                         vec_ready,
    output logic [$clog2(2*N):0]         word_count
);

    localparam int SLOTS = 2 * N;
    localparam int AW    = $clog2(SLOTS);
    localparam int CW    = AW + 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [CW-1:0] LAST_IDX = CW'(SLOTS - 1);

    logic [0:0]            state;
    logic                  started;
    logic [CW-1:0]         wc_q;
    logic [DATA_WIDTH-1:0] mem [SLOTS];
    logic                  accept;
    logic                  handoff;

    // in_ready stays low until the first edge after reset release, then follows FILL.
    assign in_ready   = started && (state == FILL);
    assign vec_valid  = (state == FULL);
    assign accept     = in_valid && in_ready;
    assign handoff    = vec_valid && vec_ready;
    assign word_count = wc_q;

    // Control: word counter and FILL/FULL sequencing; reset discards any set in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FILL;
            started <= 1'b0;
            wc_q    <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                wc_q <= wc_q + 1'b1;
                if (in_last || (wc_q == LAST_IDX)) begin
                    state <= FULL;
                end
            end else if (handoff) begin
                state <= FILL;
                wc_q  <= '0;
            end
        end
    end

    // Word storage; stale contents are never cleared because the output mask hides them.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wc_q[AW-1:0]] <= in_data;
        end
    end

    // Only slots below word_count are exposed, and only while FULL; everything else reads zero.
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        localparam logic [CW-1:0] SLOT = CW'(k);
        assign vec[k*DATA_WIDTH +: DATA_WIDTH] =
            (vec_valid && (wc_q > SLOT)) ? mem[k] : '0;
    end

endmodule

// File: tb/tb_maxi_loader.sv
// Purpose: directed self-checking bench for maxi_loader with N=2, DATA_WIDTH=8 (4 slots).
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises held FULL phases, handoff collisions and reset in FILL and FULL.
module tb_maxi_loader;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] vec;
    logic        vec_valid;
    logic        vec_ready;
    logic [2:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    maxi_loader #(.N(2), .DATA_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .vec        (vec),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_handoff(input string tag);
        vec_ready = 1'b1;
        @(posedge clock);
        #1;
        vec_ready = 1'b0;
        chk({tag, "_wc0"}, 32'(word_count), 32'd0);
        chk({tag, "_vv0"}, 32'(vec_valid), 32'd0);
        chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
    endtask

    logic [7:0] gap_dat [4];
    int         gap_len [4];

    initial begin
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        vec_ready = 1'b0;

        // reset state
        #3;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_vv", 32'(vec_valid), 32'd0);
        chk("rst_vec", vec, 32'h0);
        chk("rst_wc", 32'(word_count), 32'd0);
        #19;
        reset_n = 1'b1;
        #1;
        chk("rel_rdy_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("rel_rdy_post_edge", 32'(in_ready), 32'd1);

        // full set, back-to-back
        send(8'h11, 1'b0);
        chk("full_wc1", 32'(word_count), 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("full_vv_before_last", 32'(vec_valid), 32'd0);
        chk("full_vec_masked_fill", vec, 32'h0);
        send(8'h44, 1'b0);
        chk("full_vv", 32'(vec_valid), 32'd1);
        chk("full_vec", vec, 32'h44332211);
        chk("full_wc", 32'(word_count), 32'd4);
        chk("full_rdy", 32'(in_ready), 32'd0);
        do_handoff("ho1");

        // short set
        send(8'h05, 1'b0);
        send(8'h09, 1'b1);
        chk("short_vv", 32'(vec_valid), 32'd1);
        chk("short_vec", vec, 32'h00000905);
        chk("short_wc", 32'(word_count), 32'd2);
        do_handoff("ho2");

        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        chk("full2_vec", vec, 32'hDDCCBBAA);
        do_handoff("ho3");

        // single word with last, stale slots masked
        send(8'h01, 1'b1);
        chk("stale_vec", vec, 32'h00000001);
        chk("stale_wc", 32'(word_count), 32'd1);

        // backpressure with input pressure in FULL
        in_data  = 8'h77;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp_vec_%0d", i), vec, 32'h00000001);
            chk($sformatf("bp_rdy_%0d", i), 32'(in_ready), 32'd0);
        end
        chk("bp_wc", 32'(word_count), 32'd1);

        // handoff collision: word present during handoff cycle is not stored
        in_data   = 8'h5A;
        in_last   = 1'b0;
        vec_ready = 1'b1;
        @(posedge clock);
        #1;
        vec_ready = 1'b0;
        chk("col_wc_after_ho", 32'(word_count), 32'd0);
        chk("col_rdy", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("col_wc_slot0", 32'(word_count), 32'd1);
        send(8'h6B, 1'b0);
        send(8'h7C, 1'b0);
        send(8'h8D, 1'b1);
        chk("col_vec", vec, 32'h8D7C6B5A);
        chk("col_wc_full", 32'(word_count), 32'd4);
        do_handoff("ho4");

        // reset mid-fill
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmf_wc", 32'(word_count), 32'd0);
        chk("rmf_vec", vec, 32'h0);
        chk("rmf_rdy", 32'(in_ready), 32'd0);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        chk("rmf_vec_clean", vec, 32'h40302010);
        chk("rmf_vv", 32'(vec_valid), 32'd1);

        // reset while FULL discards the set
        #2;
        reset_n = 1'b0;
        #1;
        chk("rfull_vv", 32'(vec_valid), 32'd0);
        chk("rfull_vec", vec, 32'h0);
        #1;
        reset_n = 1'b1;
        idle(3);
        chk("rfull_vv_later", 32'(vec_valid), 32'd0);
        chk("rfull_wc_later", 32'(word_count), 32'd0);

        // gapped input; in_last without in_valid must be ignored
        gap_dat = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        gap_len = '{2, 0, 3, 1};
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap_len[i]; g++) begin
                in_last = 1'b1;
                @(posedge clock);
                #1;
                in_last = 1'b0;
                chk($sformatf("gap_idle_vv_%0d_%0d", i, g), 32'(vec_valid), 32'd0);
            end
            send(gap_dat[i], 1'b0);
            chk($sformatf("gap_wc_%0d", i), 32'(word_count), 32'(i + 1));
            chk($sformatf("gap_vv_%0d", i), 32'(vec_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("gap_vec", vec, 32'hA4A3A2A1);
        do_handoff("ho5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
